// File: rtl/ks_prefix_pipe_pkg.sv
// Shared width/level constants and the log2 helper for the Kogge-Stone prefix pipeline.
package ks_prefix_pipe_pkg;

   function automatic int ks_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   localparam int KS_WIDTH  = 16;
   localparam int KS_LEVELS = ks_clog2(KS_WIDTH);

endpackage

// File: rtl/ks_prefix_pipe_stage.sv
// One registered Kogge-Stone prefix level combining group (G,P) at distance DIST,
// carrying the raw propagate vector and carry-in alongside, with its own advance logic.
module ks_prefix_pipe_stage #(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             src_valid,
   input  logic [WIDTH-1:0] src_g,
   input  logic [WIDTH-1:0] src_p,
   input  logic [WIDTH-1:0] src_pk,
   input  logic             src_c0,
   input  logic             dst_adv,
   output logic             valid,
   output logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] pk,
   output logic             c0,
   output logic             adv
);

   logic [WIDTH-1:0] nxt_g;
   logic [WIDTH-1:0] nxt_p;

   // Bits below DIST have no partner at this distance and pass through untouched.
   always_comb begin
      nxt_g = src_g;
      nxt_p = src_p;
      for (int i = DIST; i < WIDTH; i++) begin
         nxt_g[i] = src_g[i] | (src_p[i] & src_g[i-DIST]);
         nxt_p[i] = src_p[i] & src_p[i-DIST];
      end
   end

   assign adv = !valid || dst_adv;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         g     <= '0;
         p     <= '0;
         pk    <= '0;
         c0    <= 1'b0;
      end else if (adv) begin
         valid <= src_valid;
         g     <= nxt_g;
         p     <= nxt_p;
         pk    <= src_pk;
         c0    <= src_c0;
      end
   end

endmodule

// File: rtl/ks_prefix_pipe.sv
// Pipelined Kogge-Stone prefix network and sum stage with bubble-collapsing valid/ready.
// Define KS_OVF_EN to add the registered signed-overflow output o_ovf.
module ks_prefix_pipe
   import ks_prefix_pipe_pkg::*;
#(
   parameter int WIDTH = KS_WIDTH
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_pk,
   input  logic [WIDTH-1:0] i_gk,
   input  logic             i_c0,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
`ifdef KS_OVF_EN
   ,
   output logic             o_ovf
`endif
);

   localparam int L = (WIDTH == KS_WIDTH) ? KS_LEVELS : ks_clog2(WIDTH);

   logic [WIDTH-1:0] g_s  [0:L];
   logic [WIDTH-1:0] p_s  [0:L];
   logic [WIDTH-1:0] pk_s [0:L];
   logic             c0_s [0:L];
   logic             v_s  [0:L];
   logic             adv_s [0:L+1];

   logic             s0_valid;
   logic [WIDTH-1:0] s0_g;
   logic [WIDTH-1:0] s0_p;
   logic [WIDTH-1:0] s0_pk;
   logic             s0_c0;
   logic [WIDTH-1:0] carry;

   assign adv_s[L+1] = !o_valid || i_ready;
   assign adv_s[0]   = !s0_valid || adv_s[1];
   assign o_ready    = adv_s[0];

   assign v_s[0]  = s0_valid;
   assign g_s[0]  = s0_g;
   assign p_s[0]  = s0_p;
   assign pk_s[0] = s0_pk;
   assign c0_s[0] = s0_c0;

   // Input register folds carry-in into bit 0 so the prefix tree never sees c0 separately.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s0_valid <= 1'b0;
         s0_g     <= '0;
         s0_p     <= '0;
         s0_pk    <= '0;
         s0_c0    <= 1'b0;
      end else if (adv_s[0]) begin
         s0_valid <= i_valid;
         s0_g     <= {i_gk[WIDTH-1:1], i_gk[0] | (i_pk[0] & i_c0)};
         s0_p     <= i_pk;
         s0_pk    <= i_pk;
         s0_c0    <= i_c0;
      end
   end

   for (genvar k = 1; k <= L; k++) begin : g_level
      ks_prefix_pipe_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << (k - 1))
      ) u_stage (
         .clk       (i_clk),
         .rst       (i_rst),
         .src_valid (v_s[k-1]),
         .src_g     (g_s[k-1]),
         .src_p     (p_s[k-1]),
         .src_pk    (pk_s[k-1]),
         .src_c0    (c0_s[k-1]),
         .dst_adv   (adv_s[k+1]),
         .valid     (v_s[k]),
         .g         (g_s[k]),
         .p         (p_s[k]),
         .pk        (pk_s[k]),
         .c0        (c0_s[k]),
         .adv       (adv_s[k])
      );
   end

   assign carry = {g_s[L][WIDTH-2:0], c0_s[L]};

   // Output register holds its contents whenever the consumer stalls a valid result.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid <= 1'b0;
         o_sum   <= '0;
         o_cout  <= 1'b0;
`ifdef KS_OVF_EN
         o_ovf   <= 1'b0;
`endif
      end else if (adv_s[L+1]) begin
         o_valid <= v_s[L];
         o_sum   <= pk_s[L] ^ carry;
         o_cout  <= g_s[L][WIDTH-1];
`ifdef KS_OVF_EN
         o_ovf   <= carry[WIDTH-1] ^ g_s[L][WIDTH-1];
`endif
      end
   end

endmodule

// File: tb/tb_ks_prefix_pipe.sv
// Randomized bench for ks_prefix_pipe against an a+b+c0 reference scoreboard.
module tb_ks_prefix_pipe;

   localparam int W = 16;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_valid;
   logic          o_ready;
   logic [W-1:0]  i_pk;
   logic [W-1:0]  i_gk;
   logic          i_c0;
   logic          o_valid;
   logic          i_ready;
   logic [W-1:0]  o_sum;
   logic          o_cout;
`ifdef KS_OVF_EN
   logic          o_ovf;
`endif

   int            total_checks = 0;
   int            bad_checks = 0;
   int            accept_count = 0;
   int            pop_count = 0;
   logic          popped;
   logic [17:0]   last_out;
   logic [17:0]   expect_q[$];

   always #5 i_clk = ~i_clk;

   ks_prefix_pipe dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_pk    (i_pk),
      .i_gk    (i_gk),
      .i_c0    (i_c0),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_sum   (o_sum),
      .o_cout  (o_cout)
`ifdef KS_OVF_EN
      ,
      .o_ovf   (o_ovf)
`endif
   );

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total_checks++;
      if (act !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: plain integer addition, overflow from operand/result signs.
   function automatic logic [17:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      logic [16:0] s;
      logic        ovf;
      s   = {1'b0, a} + {1'b0, b} + {16'd0, c};
      ovf = (a[15] == b[15]) && (s[15] != a[15]);
      return {ovf, s};
   endfunction

   task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic c, input logic rdy);
      logic [17:0] exp;
      logic        ovf_seen;
      i_valid = v;
      i_pk    = a ^ b;
      i_gk    = a & b;
      i_c0    = c;
      i_ready = rdy;
      #1;
      popped = 1'b0;
      if (o_valid && i_ready) begin
         if (expect_q.size() == 0) begin
            checkOutput("stale_valid", {31'd0, o_valid}, 32'd0);
         end else begin
            exp = expect_q.pop_front();
            checkOutput("sum", {16'd0, o_sum}, {16'd0, exp[15:0]});
            checkOutput("cout", {31'd0, o_cout}, {31'd0, exp[16]});
`ifdef KS_OVF_EN
            checkOutput("ovf", {31'd0, o_ovf}, {31'd0, exp[17]});
            ovf_seen = o_ovf;
`else
            ovf_seen = exp[17];
`endif
            last_out = {ovf_seen, o_cout, o_sum};
            popped   = 1'b1;
            pop_count++;
         end
      end
      if (i_valid && o_ready) begin
         expect_q.push_back(golden(a, b, c));
         accept_count++;
      end
      @(negedge i_clk);
   endtask

   task automatic drainPipe();
      for (int n = 0; n < 40 && expect_q.size() != 0; n++)
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
      checkOutput("drain_empty", expect_q.size(), 32'd0);
   endtask

   task automatic runDirected(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                              input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
      int lat;
      lat = -1;
      applyStimulus(1'b1, a, b, c, 1'b1);
      for (int n = 1; n <= 20; n++) begin
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
         if (popped && lat < 0) lat = n;
      end
      checkOutput("latency", lat, 32'd6);
      checkOutput("dir_sum", {16'd0, last_out[15:0]}, {16'd0, exp_sum});
      checkOutput("dir_cout", {31'd0, last_out[16]}, {31'd0, exp_cout});
`ifdef KS_OVF_EN
      checkOutput("dir_ovf", {31'd0, last_out[17]}, {31'd0, exp_ovf});
`else
      if (exp_ovf !== last_out[17]) checkOutput("dir_ovf_model", {31'd0, last_out[17]}, {31'd0, exp_ovf});
`endif
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_pk = '0; i_gk = '0; i_c0 = 1'b0; i_ready = 1'b1;
      @(negedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      #1;
      checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
      checkOutput("rst_sum", {16'd0, o_sum}, 32'd0);
      checkOutput("rst_cout", {31'd0, o_cout}, 32'd0);
      @(negedge i_clk);

      runDirected(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      runDirected(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      runDirected(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);

      pop_count = 0;
      for (int n = 0; n < 1000; n++)
         applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      checkOutput("stream_rate", pop_count, 32'd994);
      drainPipe();

      accept_count = 0;
      for (int n = 0; n < 10; n++) begin
         applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
         if (n == 6) checkOutput("stall_sum_a", {16'd0, o_sum}, {16'd0, expect_q[0][15:0]});
      end
      checkOutput("stall_sum_b", {16'd0, o_sum}, {16'd0, expect_q[0][15:0]});
      checkOutput("stall_held", accept_count, 32'd6);
      checkOutput("stall_valid", {31'd0, o_valid}, 32'd1);
      checkOutput("full_ready", {31'd0, o_ready}, 32'd0);
      drainPipe();

      for (int n = 0; n < 4; n++)
         applyStimulus(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0; i_valid = 1'b0;
      expect_q.delete();
      #1;
      checkOutput("flush_valid", {31'd0, o_valid}, 32'd0);
      checkOutput("flush_ready", {31'd0, o_ready}, 32'd1);
      @(negedge i_clk);
      for (int n = 0; n < 12; n++)
         applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);

      for (int n = 0; n < 400; n++)
         applyStimulus(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) != 0));
      drainPipe();

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
